addr_seq_gen: RTL and testbench

- Parametrised two-level address-pair generator.
- Emits a stream of (addr_a, addr_b) pairs, one per accepted handshake:
  - addr_b is a linear inner count.
  - addr_a follows a programmable step-back / wrap pattern driven by the current addr_b.
- Sits between the sequencing controller and the dual-port buffer address muxes.
- Generalises the fixed 4-bit dependent A/B counters: runtime-configurable jump points, step-back amount, wrap point and sequence length, plus a valid/ready output and start/done control.

---
 rtl/addr_seq_gen_if.sv | 38 +++
 rtl/addr_seq_gen.sv | 135 +++++++++++++
 tb/tb_addr_seq_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_seq_gen_if.sv
// Handshake/config bundle for addr_seq_gen; master = generator, slave = controller/consumer.
// The abort signal exists only when ADDR_SEQ_GEN_ABORT_EN is defined.
interface addr_seq_gen_if #(
  parameter int AW = 4
);
  logic          start;
  logic [AW-1:0] cfg_jump0;
  logic [AW-1:0] cfg_jump1;
  logic [AW-1:0] cfg_back;
  logic [AW-1:0] cfg_wrap_b;
  logic [AW-1:0] cfg_wrap_a;
  logic [AW-1:0] cfg_len;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
`ifdef ADDR_SEQ_GEN_ABORT_EN
  logic          abort;
`endif

  modport master (
`ifdef ADDR_SEQ_GEN_ABORT_EN
    input  abort,
`endif
    input  start, cfg_jump0, cfg_jump1, cfg_back, cfg_wrap_b, cfg_wrap_a, cfg_len, out_ready,
    output addr_a, addr_b, out_valid, busy, done
  );

  modport slave (
`ifdef ADDR_SEQ_GEN_ABORT_EN
    output abort,
`endif
    output start, cfg_jump0, cfg_jump1, cfg_back, cfg_wrap_b, cfg_wrap_a, cfg_len, out_ready,
    input  addr_a, addr_b, out_valid, busy, done
  );
endinterface

// File: rtl/addr_seq_gen.sv
// Two-level (addr_a, addr_b) pair generator with latched runtime config and valid/ready output.
// Optional feature macro: ADDR_SEQ_GEN_ABORT_EN adds an abort input that returns RUN to IDLE.
module addr_seq_gen #(
  parameter int            AW     = 4,
  parameter logic [AW-1:0] A_INIT = {AW{1'b1}}
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  addr_seq_gen_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [AW-1:0] r_addr_a;
  logic [AW-1:0] r_addr_b;
  logic [AW-1:0] r_jump0;
  logic [AW-1:0] r_jump1;
  logic [AW-1:0] r_back;
  logic [AW-1:0] r_wrap_b;
  logic [AW-1:0] r_wrap_a;
  logic [AW-1:0] r_len;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          w_accept;
  logic [AW-1:0] w_next_a;

  // Accept qualifier and the addr_a successor; jump outranks wrap.
  always_comb begin
    w_accept = r_valid && bus.out_ready;
    if ((r_addr_b == r_jump0) || (r_addr_b == r_jump1)) begin
      w_next_a = r_addr_a - r_back;
    end else if ((r_addr_b == r_wrap_b) && (r_addr_a == r_wrap_a)) begin
      w_next_a = ZERO;
    end else begin
      w_next_a = r_addr_a + ONE;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_addr_a <= A_INIT;
      r_addr_b <= ZERO;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_jump0  <= ZERO;
      r_jump1  <= ZERO;
      r_back   <= ZERO;
      r_wrap_b <= ZERO;
      r_wrap_a <= ZERO;
      r_len    <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_addr_a <= A_INIT;
          r_addr_b <= ZERO;
          r_done   <= 1'b0;
          if (bus.start) begin
            r_jump0  <= bus.cfg_jump0;
            r_jump1  <= bus.cfg_jump1;
            r_back   <= bus.cfg_back;
            r_wrap_b <= bus.cfg_wrap_b;
            r_wrap_a <= bus.cfg_wrap_a;
            r_len    <= bus.cfg_len;
            r_state  <= S_RUN;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        S_RUN: begin
`ifdef ADDR_SEQ_GEN_ABORT_EN
          // Abort beats a simultaneous accept and suppresses the done pulse.
          if (bus.abort) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_addr_a <= A_INIT;
            r_addr_b <= ZERO;
          end else
`endif
          if (w_accept) begin
            if (r_addr_b == r_len) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_RUN;
              r_addr_b <= r_addr_b + ONE;
              r_addr_a <= w_next_a;
            end
          end else begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_addr_a <= A_INIT;
          r_addr_b <= ZERO;
        end
        default: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_addr_a <= A_INIT;
          r_addr_b <= ZERO;
        end
      endcase
    end
  end

  assign bus.addr_a    = r_addr_a;
  assign bus.addr_b    = r_addr_b;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_addr_seq_gen.sv
// Self-checking bench for addr_seq_gen (AW=4, A_INIT=15) against a plain-arithmetic sequence model.
// Abort scenario compiles in only with ADDR_SEQ_GEN_ABORT_EN.
module tb_addr_seq_gen;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [3:0] cap_a[$];
  logic [3:0] cap_b[$];
  logic [3:0] exp_a[$];
  logic [3:0] exp_b[$];
  bit   timed_out;

  addr_seq_gen_if #(.AW(4)) bus();

  addr_seq_gen #(.AW(4), .A_INIT(4'd15)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk addr_b from 0 to len applying the step-back / wrap / increment rules.
  task automatic build_expected(input int j0, j1, bk, wb, wa, ln);
    int a;
    a = 15;
    exp_a.delete();
    exp_b.delete();
    for (int b = 0; b <= ln; b++) begin
      exp_a.push_back(4'(a));
      exp_b.push_back(4'(b));
      if (b == j0 || b == j1) a = (a - bk) & 15;
      else if (b == wb && a == wa) a = 0;
      else a = (a + 1) & 15;
    end
  endtask

  task automatic start_seq(input int j0, j1, bk, wb, wa, ln);
    bus.cfg_jump0  = 4'(j0);
    bus.cfg_jump1  = 4'(j1);
    bus.cfg_back   = 4'(bk);
    bus.cfg_wrap_b = 4'(wb);
    bus.cfg_wrap_a = 4'(wa);
    bus.cfg_len    = 4'(ln);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Drives out_ready and records accepted pairs until done (mode 1: random ready, mode 2: poke start/cfg at b==3).
  task automatic collect(input int mode, input int budget);
    int cyc;
    bit poked;
    cyc = 0;
    poked = 1'b0;
    timed_out = 1'b0;
    cap_a.delete();
    cap_b.delete();
    forever begin
      if (bus.done === 1'b1) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      bus.out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && !poked && bus.out_valid === 1'b1 && bus.addr_b == 4'd3) begin
        bus.start    = 1'b1;
        bus.cfg_back = 4'd3;
        bus.cfg_jump0 = 4'd7;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        cap_a.push_back(bus.addr_a);
        cap_b.push_back(bus.addr_b);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.busy, bus.done, bus.addr_a, bus.addr_b} !== {3'b000, 4'd15, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b busy=%b done=%b a=%0d b=%0d, expected 0 0 0 15 0",
               bus.out_valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.addr_a !== 4'd15) begin
      n_fail++;
      $display("FAIL idle_after_reset: got v=%b a=%0d, expected v=0 a=15", bus.out_valid, bus.addr_a);
    end
  endtask

  task automatic test_baseline;
    logic [3:0] gold [10];
    gold = '{4'd15, 4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd2};
    @(negedge clk);
    start_seq(2, 5, 2, 8, 8, 9);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.addr_a !== 4'd15 || bus.addr_b !== 4'd0) begin
      n_fail++;
      $display("FAIL baseline_first: got v=%b busy=%b (%0d,%0d), expected 1 1 (15,0)",
               bus.out_valid, bus.busy, bus.addr_a, bus.addr_b);
    end
    collect(0, 100);
    n_tests++;
    if (timed_out || cap_a.size() != 10) begin
      n_fail++;
      $display("FAIL baseline_count: got %0d pairs (timeout=%0d), expected 10", cap_a.size(), timed_out);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (cap_a[i] !== gold[i] || cap_b[i] !== 4'(i)) begin
          n_fail++;
          $display("FAIL baseline_pair%0d: got (%0d,%0d), expected (%0d,%0d)", i, cap_a[i], cap_b[i], gold[i], i);
        end
      end
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL baseline_done: got done=%b v=%b busy=%b, expected 1 0 0", bus.done, bus.out_valid, bus.busy);
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.addr_a !== 4'd15 || bus.addr_b !== 4'd0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got done=%b (%0d,%0d), expected 0 (15,0)", bus.done, bus.addr_a, bus.addr_b);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] gold [11];
    gold = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd1};
    @(negedge clk);
    start_seq(15, 15, 0, 8, 7, 10);
    collect(0, 100);
    n_tests++;
    if (timed_out || cap_a.size() != 11) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d pairs, expected 11", cap_a.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_tests++;
        if (cap_a[i] !== gold[i]) begin
          n_fail++;
          $display("FAIL wrap_a%0d: got %0d, expected %0d", i, cap_a[i], gold[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int accepts;
    bit stalled;
    accepts = 0;
    stalled = 1'b0;
    build_expected(2, 5, 2, 8, 8, 9);
    @(negedge clk);
    start_seq(2, 5, 2, 8, 8, 9);
    for (int cyc = 0; cyc < 60 && bus.done !== 1'b1; cyc++) begin
      if (!stalled && bus.out_valid === 1'b1 && bus.addr_b == 4'd4) begin
        stalled = 1'b1;
        for (int k = 0; k < 3; k++) begin
          bus.out_ready = 1'b0;
          @(negedge clk);
          n_tests++;
          if (bus.out_valid !== 1'b1 || bus.addr_a !== 4'd0 || bus.addr_b !== 4'd4) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got v=%b (%0d,%0d), expected 1 (0,4)", k, bus.out_valid, bus.addr_a, bus.addr_b);
          end
        end
      end
      bus.out_ready = 1'b1;
      if (bus.out_valid === 1'b1) begin
        n_tests++;
        if (accepts >= exp_a.size() || bus.addr_a !== exp_a[accepts] || bus.addr_b !== exp_b[accepts]) begin
          n_fail++;
          $display("FAIL stall_seq%0d: got (%0d,%0d), expected next model pair", accepts, bus.addr_a, bus.addr_b);
        end
        accepts++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (accepts != 10 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_total: got %0d accepts done=%b, expected 10 accepts and done=1", accepts, bus.done);
    end
  endtask

  task automatic test_reset_mid_run;
    bit found;
    found = 1'b0;
    build_expected(2, 5, 2, 8, 8, 9);
    @(negedge clk);
    start_seq(2, 5, 2, 8, 8, 9);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1 && bus.addr_a == 4'd1 && bus.addr_b == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL midrun_reach: got pair (1,5) seen=0, expected 1");
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.addr_a !== 4'd15 || bus.addr_b !== 4'd0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got v=%b busy=%b (%0d,%0d), expected 0 0 (15,0)",
               bus.out_valid, bus.busy, bus.addr_a, bus.addr_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_seq(2, 5, 2, 8, 8, 9);
    collect(0, 100);
    n_tests++;
    if (timed_out || cap_a != exp_a || cap_b != exp_b) begin
      n_fail++;
      $display("FAIL midrun_replay: got %0d pairs first=(%0d,%0d), expected %0d pairs from (15,0)",
               cap_a.size(), cap_a.size() > 0 ? cap_a[0] : 4'd0, cap_b.size() > 0 ? cap_b[0] : 4'd0, exp_a.size());
    end
  endtask

  task automatic test_ignored_start;
    build_expected(2, 5, 2, 8, 8, 9);
    @(negedge clk);
    start_seq(2, 5, 2, 8, 8, 9);
    collect(2, 100);
    n_tests++;
    if (timed_out || cap_a != exp_a || cap_b != exp_b) begin
      n_fail++;
      $display("FAIL ignored_start: got %0d pairs, a[6]=%0d, expected %0d pairs, a[6]=15",
               cap_a.size(), cap_a.size() > 6 ? cap_a[6] : 4'd0, exp_a.size());
    end
  endtask

  task automatic test_len_zero;
    @(negedge clk);
    start_seq(0, 0, 1, 0, 15, 0);
    collect(0, 20);
    n_tests++;
    if (timed_out || cap_a.size() != 1 || cap_a[0] !== 4'd15 || cap_b[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL len_zero: got %0d pairs, expected exactly (15,0)", cap_a.size());
    end
  endtask

  task automatic test_random;
    int j0, j1, bk, wb, wa, ln;
    for (int it = 0; it < 8; it++) begin
      j0 = $urandom_range(0, 15); j1 = $urandom_range(0, 15); bk = $urandom_range(0, 15);
      wb = $urandom_range(0, 15); wa = $urandom_range(0, 15); ln = $urandom_range(0, 15);
      build_expected(j0, j1, bk, wb, wa, ln);
      @(negedge clk);
      start_seq(j0, j1, bk, wb, wa, ln);
      collect(1, 200);
      n_tests++;
      if (timed_out || cap_a != exp_a || cap_b != exp_b) begin
        n_fail++;
        $display("FAIL random%0d: got %0d pairs, expected %0d (j0=%0d j1=%0d bk=%0d wb=%0d wa=%0d len=%0d)",
                 it, cap_a.size(), exp_a.size(), j0, j1, bk, wb, wa, ln);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start_seq(1, 9, 5, 3, 3, 6);
    collect(0, 50);
    @(negedge clk);
    build_expected(4, 4, 7, 12, 2, 13);
    start_seq(4, 4, 7, 12, 2, 13);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: got v=%b busy=%b, expected 1 1", bus.out_valid, bus.busy);
    end
    collect(0, 50);
    n_tests++;
    if (timed_out || cap_a != exp_a || cap_b != exp_b) begin
      n_fail++;
      $display("FAIL b2b_seq: got %0d pairs, expected %0d", cap_a.size(), exp_a.size());
    end
  endtask

`ifdef ADDR_SEQ_GEN_ABORT_EN
  task automatic test_abort;
    bit found;
    int dones;
    found = 1'b0;
    dones = 0;
    @(negedge clk);
    start_seq(2, 5, 2, 8, 8, 9);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1 && bus.addr_b == 4'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_tests++;
    if (!found || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.addr_a !== 4'd15 || bus.addr_b !== 4'd0) begin
      n_fail++;
      $display("FAIL abort: got seen=%0d v=%b busy=%b done=%b (%0d,%0d), expected 1 0 0 0 (15,0)",
               found, bus.out_valid, bus.busy, bus.done, bus.addr_a, bus.addr_b);
    end
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done cycles, expected 0", dones);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    bus.cfg_jump0 = 4'd0; bus.cfg_jump1 = 4'd0; bus.cfg_back = 4'd0;
    bus.cfg_wrap_b = 4'd0; bus.cfg_wrap_a = 4'd0; bus.cfg_len = 4'd0;
`ifdef ADDR_SEQ_GEN_ABORT_EN
    bus.abort = 1'b0;
`endif
    test_reset();
    test_baseline();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
    test_ignored_start();
    test_len_zero();
    test_random();
    test_back_to_back();
`ifdef ADDR_SEQ_GEN_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
